ifu_prefetch: RTL

Parametrised instruction-fetch unit that replaces the single-register PC/next-PC path of the single-cycle core. It owns the fetch PC and issues sequential requests to instruction memory over a valid/ready handshake, tolerating multiple outstanding requests. Returned words land in a prefetch FIFO that presents {pc, inst} to decode. A redirect from execute (branch, jal or jalr target) flushes the FIFO and discards stale in-flight responses.

---
 rtl/ifu_pkg.sv | 16 +
 rtl/ifu_fifo.sv | 49 ++++
 rtl/ifu_prefetch.sv | 105 ++++++++++
 3 files changed

// File: rtl/ifu_pkg.sv
// Shared types and sizing helpers for the instruction-fetch unit.
package ifu_pkg;
    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam int          INST_W       = 32;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [INST_W-1:0]   inst;
    } fetch_entry_t;

    // Width able to hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO: registered storage, flush, push/pop, simultaneous push+pop legal when full.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  entry_t                push_data,
    input  logic                  pop,
    output entry_t                head,
    output logic [occ_w(DEPTH)-1:0] count,
    output logic                  full,
    output logic                  empty
);
    localparam int CW = occ_w(DEPTH);
    localparam int AW = $clog2(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; contents are only observed through count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit with prefetch FIFO, multiple outstanding requests and redirect flush.
// Optional misaligned-redirect check/halt under macro IFU_MISALIGN_CHK_EN.
module ifu_prefetch
    import ifu_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int              DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [XLEN-1:0]   inst_pc,
    output logic              misalign_err
);
    localparam int CW = occ_w(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } entry_t;

`ifdef IFU_MISALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic [XLEN-1:0] fetch_pc, rsp_pc, redir_tgt;
    logic [CW-1:0]   outstanding, drop_cnt, fifo_count, out_next;
    logic [CW:0]     occ;
    logic            active, halted, misalign, bad_redir;
    logic            req_fire, push, pop, fifo_full, fifo_empty;
    entry_t          head, push_data;

    assign redir_tgt = CHK_EN ? redirect_pc : (redirect_pc & ~XLEN'(3));
    assign bad_redir = CHK_EN && redirect_valid && (redirect_pc[1:0] != 2'b00);

    // FIFO entries plus in-flight requests never exceed DEPTH, so the FIFO cannot overflow.
    assign occ            = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = active && !halted && !redirect_valid && (occ < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign out_next       = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    assign pop       = inst_valid && inst_ready;
    assign push      = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid && (!fifo_full || pop);
    assign push_data = '{pc: rsp_pc, inst: imem_rsp_data};

    assign inst_valid   = !fifo_empty;
    assign inst_pc      = head.pc;
    assign inst_data    = head.inst;
    assign misalign_err = misalign;

    ifu_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            active      <= 1'b0;
            halted      <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            active      <= 1'b1;
            outstanding <= out_next;
            if (redirect_valid) begin
                // Everything still in flight belongs to the old path.
                fetch_pc <= redir_tgt;
                rsp_pc   <= redir_tgt;
                drop_cnt <= out_next;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (push)     rsp_pc   <= rsp_pc + XLEN'(4);
                if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
            end
            if (bad_redir) begin
                misalign <= 1'b1;
                halted   <= 1'b1;
            end
        end
    end
endmodule
